// File: rtl/systolic_mm_pkg.sv
// systolic_mm_pkg: shared FSM state type and sizing helpers
// for the systolic_mm_engine slice.
package systolic_mm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      UNLOAD
   } mm_state_t;

   // $clog2 that never returns 0, so index ports keep one bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // cycles for the last skewed beat to reach the far corner PE
   function automatic int drain_cycles(input int rows,
                                       input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/systolic_mm_if.sv
// systolic_mm_if: job control, operand stream and result stream.
// slave = engine side, master = host side. SYSTOLIC_MM_SAT_EN adds sat_flag.
interface systolic_mm_if
   import systolic_mm_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int ACC_W = 24,
   parameter int KMAX  = 256
);
   localparam int KW = $clog2(KMAX + 1);
   localparam int RW = clog2_min1(ROWS);

   logic                  start;
   logic [KW-1:0]         k_len;
   logic                  busy;
   logic                  in_valid;
   logic                  in_ready;
   logic [ROWS*DW-1:0]    a_din;
   logic [COLS*DW-1:0]    b_din;
   logic                  out_valid;
   logic                  out_ready;
   logic [COLS*ACC_W-1:0] c_out;
   logic [RW-1:0]         out_row;
   logic                  done;
`ifdef SYSTOLIC_MM_SAT_EN
   logic                  sat_flag;
`endif

   modport slave (
`ifdef SYSTOLIC_MM_SAT_EN
      output sat_flag,
`endif
      input  start, k_len, in_valid, a_din, b_din, out_ready,
      output busy, in_ready, out_valid, c_out, out_row, done
   );

   modport master (
`ifdef SYSTOLIC_MM_SAT_EN
      input  sat_flag,
`endif
      output start, k_len, in_valid, a_din, b_din, out_ready,
      input  busy, in_ready, out_valid, c_out, out_row, done
   );

endinterface

// File: rtl/systolic_mm_pe.sv
// systolic_mm_pe: one output-stationary cell. Ports: a/b + tags in,
// registered a/b + tags out, clr, acc (and sat with SYSTOLIC_MM_SAT_EN).
module systolic_mm_pe
   import systolic_mm_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic signed [DW-1:0]    a_in,
   input  logic                    a_tag_in,
   input  logic signed [DW-1:0]    b_in,
   input  logic                    b_tag_in,
   output logic signed [DW-1:0]    a_out,
   output logic                    a_tag_out,
   output logic signed [DW-1:0]    b_out,
   output logic                    b_tag_out,
`ifdef SYSTOLIC_MM_SAT_EN
   output logic                    sat,
`endif
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*DW-1:0] prod;
   logic                   hit;

   assign prod = a_in * b_in;
   assign hit  = a_tag_in & b_tag_in;

`ifdef SYSTOLIC_MM_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // one guard bit is enough: both addends fit in ACC_W
   logic signed [ACC_W:0] sum;
   assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (hit && !sat) begin
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
            sat <= 1'b1;
         end else begin
            acc <= sum[ACC_W-1:0];
         end
      end
   end
`else
   logic signed [ACC_W-1:0] pext;
   assign pext = ACC_W'(prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (hit)
         acc <= acc + pext;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_out     <= '0;
         b_out     <= '0;
         a_tag_out <= 1'b0;
         b_tag_out <= 1'b0;
      end else begin
         a_out     <= a_in;
         b_out     <= b_in;
         a_tag_out <= a_tag_in;
         b_tag_out <= b_tag_in;
      end
   end

endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: ROWS x COLS output-stationary matmul with input skew,
// job FSM and row unload. Ports: clk, rst, bus (systolic_mm_if.slave).
// SYSTOLIC_MM_SAT_EN: saturating accumulators and sat_flag.
module systolic_mm_engine
   import systolic_mm_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int ACC_W = 24,
   parameter int KMAX  = 256
) (
   input  logic         clk,
   input  logic         rst,
   systolic_mm_if.slave bus
);

   localparam int KW  = $clog2(KMAX + 1);
   localparam int RW  = clog2_min1(ROWS);
   localparam int DC  = drain_cycles(ROWS, COLS);
   localparam int DCW = $clog2(DC + 1);

   mm_state_t      state;
   logic [KW-1:0]  k_lat;
   logic [KW-1:0]  k_cnt;
   logic [DCW-1:0] drain_cnt;
   logic [RW-1:0]  row_cnt;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           start_ok;
   logic           hs_in;
   logic           hs_out;

   assign start_ok = (state == IDLE) & bus.start;
   assign hs_in    = bus.in_valid & in_ready_q;
   assign hs_out   = out_valid_q & bus.out_ready;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state != IDLE);
   assign bus.out_row   = row_cnt;
   assign bus.done      = hs_out & (row_cnt == RW'(ROWS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         k_lat       <= '0;
         k_cnt       <= '0;
         drain_cnt   <= '0;
         row_cnt     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  k_lat     <= bus.k_len;
                  k_cnt     <= '0;
                  drain_cnt <= '0;
                  if (bus.k_len != '0) begin
                     state      <= LOAD;
                     in_ready_q <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            LOAD: begin
               if (hs_in) begin
                  k_cnt <= k_cnt + KW'(1);
                  if ((k_cnt + KW'(1)) == k_lat) begin
                     in_ready_q <= 1'b0;
                     drain_cnt  <= '0;
                     state      <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == DCW'(DC - 1)) begin
                  row_cnt     <= '0;
                  out_valid_q <= 1'b1;
                  state       <= UNLOAD;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            UNLOAD: begin
               if (hs_out) begin
                  if (row_cnt == RW'(ROWS - 1)) begin
                     row_cnt     <= '0;
                     out_valid_q <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end
            end
         endcase
      end
   end

   // a flows west->east, b north->south; tags mark real beats
   logic signed [DW-1:0]    a_h  [ROWS][COLS+1];
   logic                    at_h [ROWS][COLS+1];
   logic signed [DW-1:0]    b_v  [ROWS+1][COLS];
   logic                    bt_v [ROWS+1][COLS];
   logic signed [ACC_W-1:0] acc  [ROWS][COLS];

   // row i of A is delayed i cycles so the wavefront lines up
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
      if (gi == 0) begin : g_d0
         assign a_h[0][0]  = bus.a_din[0 +: DW];
         assign at_h[0][0] = hs_in;
      end else begin : g_dn
         logic signed [DW-1:0] d [gi];
         logic                 t [gi];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < gi; s++) begin
                  d[s] <= '0;
                  t[s] <= 1'b0;
               end
            end else begin
               d[0] <= bus.a_din[gi*DW +: DW];
               t[0] <= hs_in;
               for (int s = 1; s < gi; s++) begin
                  d[s] <= d[s-1];
                  t[s] <= t[s-1];
               end
            end
         end
         assign a_h[gi][0]  = d[gi-1];
         assign at_h[gi][0] = t[gi-1];
      end
   end

   for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
      if (gj == 0) begin : g_d0
         assign b_v[0][0]  = bus.b_din[0 +: DW];
         assign bt_v[0][0] = hs_in;
      end else begin : g_dn
         logic signed [DW-1:0] d [gj];
         logic                 t [gj];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < gj; s++) begin
                  d[s] <= '0;
                  t[s] <= 1'b0;
               end
            end else begin
               d[0] <= bus.b_din[gj*DW +: DW];
               t[0] <= hs_in;
               for (int s = 1; s < gj; s++) begin
                  d[s] <= d[s-1];
                  t[s] <= t[s-1];
               end
            end
         end
         assign b_v[0][gj]  = d[gj-1];
         assign bt_v[0][gj] = t[gj-1];
      end
   end

`ifdef SYSTOLIC_MM_SAT_EN
   logic sat [ROWS][COLS];
`endif

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
         systolic_mm_pe #(
            .DW    (DW),
            .ACC_W (ACC_W)
         ) u_pe (
            .clk       (clk),
            .rst       (rst),
            .clr       (start_ok),
            .a_in      (a_h[gi][gj]),
            .a_tag_in  (at_h[gi][gj]),
            .b_in      (b_v[gi][gj]),
            .b_tag_in  (bt_v[gi][gj]),
            .a_out     (a_h[gi][gj+1]),
            .a_tag_out (at_h[gi][gj+1]),
            .b_out     (b_v[gi+1][gj]),
            .b_tag_out (bt_v[gi+1][gj]),
`ifdef SYSTOLIC_MM_SAT_EN
            .sat       (sat[gi][gj]),
`endif
            .acc       (acc[gi][gj])
         );
      end
   end

   always_comb begin
      bus.c_out = '0;
      for (int j = 0; j < COLS; j++)
         bus.c_out[j*ACC_W +: ACC_W] = acc[row_cnt][j];
   end

`ifdef SYSTOLIC_MM_SAT_EN
   logic row_sat;
   logic sat_q;

   always_comb begin
      row_sat = 1'b0;
      for (int j = 0; j < COLS; j++)
         row_sat = row_sat | sat[row_cnt][j];
   end

   // sticky for the job; visible already on the flagging handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sat_q <= 1'b0;
      else if (start_ok)
         sat_q <= 1'b0;
      else if (hs_out && row_sat)
         sat_q <= 1'b1;
   end

   assign bus.sat_flag = sat_q | (hs_out & row_sat);
`endif

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: directed + random jobs on a 4x3 array,
// ACC_W=16, checked against a matrix-product reference model.
module tb_systolic_mm_engine;

   localparam int DW    = 8;
   localparam int ROWS  = 4;
   localparam int COLS  = 3;
   localparam int ACC_W = 16;
   localparam int KMAX  = 15;
   localparam int KW    = $clog2(KMAX + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_mm_if #(
      .DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .KMAX(KMAX)
   ) bus ();

   systolic_mm_engine #(
      .DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .KMAX(KMAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     a_m [ROWS][KMAX];
   int     b_m [KMAX][COLS];
   longint exp_c [ROWS][COLS];
   bit     exp_sat [ROWS];
   longint got [ROWS][COLS];

   task automatic check(input string tag,
                        input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // C = A*B element by element, in k order, with ACC_W arithmetic
   function automatic void model(input int k);
      longint m = longint'(1) << ACC_W;
      longint hi = (m / 2) - 1;
      longint lo = -(m / 2);
      for (int i = 0; i < ROWS; i++) begin
         exp_sat[i] = 1'b0;
         for (int j = 0; j < COLS; j++) begin
            longint acc = 0;
            bit st = 1'b0;
            for (int kk = 0; kk < k; kk++) begin
               longint s = acc + longint'(a_m[i][kk] * b_m[kk][j]);
`ifdef SYSTOLIC_MM_SAT_EN
               if (!st) begin
                  if (s > hi) begin
                     acc = hi; st = 1'b1;
                  end else if (s < lo) begin
                     acc = lo; st = 1'b1;
                  end else begin
                     acc = s;
                  end
               end
`else
               acc = ((s % m) + m) % m;
               if (acc > hi) acc = acc - m;
`endif
            end
            exp_c[i][j] = acc;
            exp_sat[i] = exp_sat[i] | st;
         end
      end
   endfunction

   function automatic void fill_const(input int v);
      for (int i = 0; i < ROWS; i++)
         for (int k = 0; k < KMAX; k++) a_m[i][k] = v;
      for (int k = 0; k < KMAX; k++)
         for (int j = 0; j < COLS; j++) b_m[k][j] = v;
   endfunction

   function automatic void fill_random();
      for (int i = 0; i < ROWS; i++)
         for (int k = 0; k < KMAX; k++)
            a_m[i][k] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < KMAX; k++)
         for (int j = 0; j < COLS; j++)
            b_m[k][j] = int'($urandom_range(255)) - 128;
   endfunction

   task automatic drive_beat(input int idx);
      for (int i = 0; i < ROWS; i++)
         bus.a_din[i*DW +: DW] = a_m[i][idx][DW-1:0];
      for (int j = 0; j < COLS; j++)
         bus.b_din[j*DW +: DW] = b_m[idx][j][DW-1:0];
   endtask

   task automatic run_job(input string name, input int k,
                          input bit bubbles, input int stall_row,
                          input int stall_len, input bit poke);
      int idx = 0;
      int last = 0;
      int guard = 0;
      bit tog = 1'b0;
      bit sat_acc = 1'b0;
      model(k);
      @(negedge clk);
      bus.start = 1'b1;
      bus.k_len = KW'(k);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check({name, " busy"}, bus.busy, 1);
      while (idx < k && guard < 200) begin
         bus.in_valid = bubbles ? tog : 1'b1;
         tog = !tog;
         drive_beat(idx < KMAX ? idx : 0);
         #1;
         if (bus.in_valid && bus.in_ready) begin
            if (idx == k - 1) last = cyc;
            idx++;
         end
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b0;
      #1;
      check({name, " beats"}, idx, k);
      check({name, " in_ready_low"}, bus.in_ready, 0);
      guard = 0;
      while (!bus.out_valid && guard < 100) begin
         bus.start = (poke && guard == 1);
         bus.k_len = KW'(5);
         @(negedge clk);
         #1;
         guard++;
      end
      bus.start = 1'b0;
      check({name, " out_valid"}, bus.out_valid, 1);
      if (k > 0)
         check({name, " latency"}, cyc - last, ROWS + COLS);
      for (int r = 0; r < ROWS; r++) begin
         if (r == stall_row) begin
            for (int s = 0; s < stall_len; s++) begin
               bus.out_ready = 1'b0;
               #1;
               check($sformatf("%s hold_row r%0d", name, r),
                     bus.out_row, r);
               check($sformatf("%s hold_c0 r%0d", name, r),
                     $signed(bus.c_out[0 +: ACC_W]), exp_c[r][0]);
               check($sformatf("%s hold_done r%0d", name, r),
                     bus.done, 0);
               @(negedge clk);
               #1;
            end
         end
         bus.out_ready = 1'b1;
         #1;
         check($sformatf("%s valid r%0d", name, r), bus.out_valid, 1);
         check($sformatf("%s out_row r%0d", name, r), bus.out_row, r);
         for (int j = 0; j < COLS; j++) begin
            got[r][j] = $signed(bus.c_out[j*ACC_W +: ACC_W]);
            check($sformatf("%s c[%0d][%0d]", name, r, j),
                  $signed(bus.c_out[j*ACC_W +: ACC_W]), exp_c[r][j]);
         end
         check($sformatf("%s done r%0d", name, r),
               bus.done, (r == ROWS - 1));
         sat_acc = sat_acc | exp_sat[r];
`ifdef SYSTOLIC_MM_SAT_EN
         check($sformatf("%s sat_flag r%0d", name, r),
               bus.sat_flag, sat_acc);
`endif
         @(negedge clk);
         #1;
      end
      bus.out_ready = 1'b0;
      #1;
      check({name, " end_valid"}, bus.out_valid, 0);
      check({name, " end_busy"}, bus.busy, 0);
      check({name, " end_done"}, bus.done, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.in_valid = 1'b0;
      bus.a_din = '0;
      bus.b_din = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst in_ready", bus.in_ready, 0);
      check("rst out_valid", bus.out_valid, 0);
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst c_out", bus.c_out, 0);
      check("rst out_row", bus.out_row, 0);
      rst = 1'b0;

      // 2x2 known values embedded in the 4x3 array
      fill_const(0);
      a_m[0][0] = 1; a_m[0][1] = 2;
      a_m[1][0] = 3; a_m[1][1] = 4;
      b_m[0][0] = 5; b_m[0][1] = 6;
      b_m[1][0] = 7; b_m[1][1] = 8;
      run_job("known", 2, 1'b0, -1, 0, 1'b0);
      check("known 19", got[0][0], 19);
      check("known 22", got[0][1], 22);
      check("known 43", got[1][0], 43);
      check("known 50", got[1][1], 50);

      run_job("bubble", 2, 1'b1, -1, 0, 1'b0);
      check("bubble 19", got[0][0], 19);
      check("bubble 50", got[1][1], 50);

      run_job("backpr", 2, 1'b0, 0, 3, 1'b0);
      check("backpr 43", got[1][0], 43);

      fill_const(-128);
      run_job("neg", 1, 1'b0, -1, 0, 1'b1);
      check("neg 16384", got[ROWS-1][COLS-1], 16384);

      run_job("k0", 0, 1'b0, -1, 0, 1'b0);
      check("k0 zero", got[ROWS-1][COLS-1], 0);

      fill_const(127);
      run_job("big", 4, 1'b0, 2, 1, 1'b0);
`ifdef SYSTOLIC_MM_SAT_EN
      check("big sat", got[0][0], 32767);
`else
      check("big wrap", got[0][0], -1020);
`endif

      for (int t = 0; t < 6; t++) begin
         fill_random();
         run_job($sformatf("rnd%0d", t), int'($urandom_range(KMAX, 1)),
                 1'($urandom_range(1)), int'($urandom_range(ROWS)),
                 int'($urandom_range(3)), 1'($urandom_range(1)));
      end

      // abort a job in LOAD, then a clean job must see no residue
      fill_const(50);
      @(negedge clk);
      bus.start = 1'b1;
      bus.k_len = KW'(6);
      @(negedge clk);
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      drive_beat(0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort in_ready", bus.in_ready, 0);
      check("abort out_valid", bus.out_valid, 0);
      check("abort busy", bus.busy, 0);
      check("abort done", bus.done, 0);
      check("abort c_out", bus.c_out, 0);
      check("abort out_row", bus.out_row, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      fill_random();
      run_job("fresh", 5, 1'b1, 1, 2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
